port_bus_arbiter: RTL and testbench
===================================

# port_bus_arbiter

Shares the single I/O port bus of the port controller between two requesters: requester A, the CPU core, and requester B, the debug monitor. Each requester issues one read or write at a time with a level request. The block serialises them, drives the bus strobes with the timing the port controller expects, and returns read data with a one-cycle acknowledge. It sits between the requesters and the port controller's port_addr/port_in/port_out/port_bit/port_clk/port_read pins.

## Interface
Parameters:
- READ_WAIT, default 2: cycles port_read stays high per read. Legal range 1..15; the counter is 4 bits.

Ports:
- clock50 — in, 1: single clock. All state updates on the rising edge.
- reset — in, 1: synchronous, active-high.
- a_req / b_req — in, 1: level request, held until the matching ack.
- a_addr / b_addr — in, 16: port address.
- a_wdata / b_wdata — in, 16: write data.
- a_we / b_we — in, 1: 1 = write, 0 = read.
- a_bit / b_bit — in, 1: access width, passed through to port_bit.
- a_ack / b_ack — out, 1: one-cycle completion pulse.
- rdata — out, 16: read data. Valid while either ack is high; holds its value otherwise.
- port_addr — out, 16: bus address.
- port_out — out, 16: bus write data.
- port_bit — out, 1: bus width.
- port_clk — out, 1: write strobe.
- port_read — out, 1: read strobe.
- port_in — in, 16: bus read data from the port controller.

## Operation
- All outputs are registered.
- Reset values: every output is 0, state is IDLE, and the last-grant pointer is B, so A wins the first tie.
- State machine states: IDLE, RD, WR, END.
- IDLE:
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner. With both requesting, grant the requester that was not granted last; the pointer updates on every grant.
  - Latch the winner's addr, wdata and bit onto port_addr, port_out and port_bit.
  - Go to RD with port_read=1 and cnt=READ_WAIT-1, or go to WR with port_clk=1.
- RD:
  - port_read is 1.
  - If cnt≠0, decrement cnt.
  - If cnt=0, capture port_in into rdata, drop port_read, raise the winner's ack, and go to END.
- WR: drop port_clk (one-cycle pulse), raise the winner's ack, and go to END.
- END:
  - Both strobes are 0, port_addr is still held, and ack is high.
  - Next cycle: ack=0, go to IDLE.
  - Holding the address here is mandatory: the port controller acts on the falling edge of port_read and decodes port_addr one cycle later.
- Requester rule: deassert req on the same edge at which ack is sampled high. A req still high in the IDLE cycle after END is a new transaction.
- Request inputs (addr, wdata, we, bit) must be stable while req is high. They are sampled only in IDLE.
- A request arriving while the bus is busy waits; there is no abort and no preemption.
- Reset mid-transaction: next edge forces IDLE with all strobes 0 and no ack issued. A port_read drop caused by reset may be seen by the port controller as a read; software must tolerate this.

## Timing
- Read: req sampled in IDLE at edge t.
  - port_read is high for cycles t+1 .. t+READ_WAIT.
  - rdata is valid and ack is high in cycle t+READ_WAIT+1 (END).
  - IDLE again at t+READ_WAIT+2.
- Write: port_clk is high in cycle t+1; ack is high in t+2; IDLE at t+3.
- Back-to-back minimum occupancy: a read takes READ_WAIT+2 cycles and a write takes 3 cycles, including IDLE.
- port_addr changes only on the edge that leaves IDLE with a grant.

## Configuration
- PORT_ARB_FIXED_PRIO_EN:
  - Defined: A always wins simultaneous requests; the last-grant pointer is not implemented. B can starve while A requests continuously.
  - Undefined (default): round-robin as described under Operation.

## Test plan
- Single A read, READ_WAIT=2, a_addr=0x0060, port_in=0x0041: port_read high for exactly 2 cycles. a_ack is high 3 cycles after the grant edge with rdata=0x0041. port_addr=0x0060 through END.
- Single B write, b_addr=0x0064, b_wdata=0x1234: one port_clk pulse with port_out=0x1234. b_ack is high the next cycle. a_ack stays 0.
- A and B requesting simultaneously and continuously after reset: grants alternate A, B, A, B. Each ack is exactly one cycle. With PORT_ARB_FIXED_PRIO_EN defined, only A is served.
- Reset asserted on the second RD cycle: port_read is 0 and state is IDLE next cycle. No ack is issued. All outputs equal their reset values.
- req held high one cycle after ack (protocol violation): a second identical transaction runs. Confirms sampling happens only in IDLE and no transaction is duplicated before that.

Source files
------------

// File: rtl/port_bus_arbiter.sv
// port_bus_arbiter
//   Shares the port controller's single I/O bus between requester A (CPU core)
//   and requester B (debug monitor). Each requester raises a level request and
//   holds it until its one-cycle ack. The arbiter serialises the accesses,
//   drives the write strobe (port_clk) and read strobe (port_read), and
//   returns read data alongside the ack.
//
//   Build option:
//     PORT_ARB_FIXED_PRIO_EN - when defined, A always wins simultaneous
//                              requests and no last-grant pointer exists.
//                              When undefined, ties alternate (round-robin).
//
//   Ports:
//     clock50              in   single clock, rising edge
//     reset                in   synchronous, active-high
//     a_req / b_req        in   level request, held until matching ack
//     a_addr / b_addr      in   16-bit port address
//     a_wdata / b_wdata    in   16-bit write data
//     a_we / b_we          in   1 = write, 0 = read
//     a_bit / b_bit        in   access width, forwarded to port_bit
//     a_ack / b_ack        out  one-cycle completion pulse
//     rdata                out  read data, valid with ack, held otherwise
//     port_addr            out  bus address (held from grant through END)
//     port_out             out  bus write data
//     port_bit             out  bus width
//     port_clk             out  one-cycle write strobe
//     port_read            out  read strobe, READ_WAIT cycles
//     port_in              in   bus read data from the port controller
module port_bus_arbiter #(
  parameter int READ_WAIT = 2
) (
  input  logic        clock50,
  input  logic        reset,
  input  logic        a_req,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic        a_we,
  input  logic        a_bit,
  input  logic        b_req,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic        b_we,
  input  logic        b_bit,
  output logic        a_ack,
  output logic        b_ack,
  output logic [15:0] rdata,
  output logic [15:0] port_addr,
  output logic [15:0] port_out,
  output logic        port_bit,
  output logic        port_clk,
  output logic        port_read,
  input  logic [15:0] port_in
);

  localparam logic [3:0] CNT_INIT = 4'(READ_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        win_b_q, win_b_d;      // 1 = current transaction belongs to B
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        bit_q, bit_d;
  logic        clk_q, clk_d;
  logic        read_q, read_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic        grant_b;

`ifdef PORT_ARB_FIXED_PRIO_EN
  // A has absolute priority; B only wins when A is idle.
  always_comb begin
    grant_b = b_req & ~a_req;
  end
`else
  logic last_b_q, last_b_d;           // 1 = last grant went to B

  // On a tie, B wins only if A was granted last.
  always_comb begin
    grant_b = b_req & (~a_req | ~last_b_q);
  end

  always_comb begin
    last_b_d = last_b_q;
    if (state_q == S_IDLE && (a_req || b_req)) begin
      last_b_d = grant_b;
    end
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      last_b_q <= 1'b1;               // so A wins the first tie
    end else begin
      last_b_q <= last_b_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_b_d = win_b_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bit_d   = bit_q;
    clk_d   = 1'b0;
    read_d  = 1'b0;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          win_b_d = grant_b;
          addr_d  = grant_b ? b_addr  : a_addr;
          wdata_d = grant_b ? b_wdata : a_wdata;
          bit_d   = grant_b ? b_bit   : a_bit;
          if (grant_b ? b_we : a_we) begin
            state_d = S_WR;
            clk_d   = 1'b1;
          end else begin
            state_d = S_RD;
            read_d  = 1'b1;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_RD: begin
        if (cnt_q != 4'd0) begin
          cnt_d  = cnt_q - 4'd1;
          read_d = 1'b1;
        end else begin
          rdata_d = port_in;
          a_ack_d = ~win_b_q;
          b_ack_d = win_b_q;
          state_d = S_END;
        end
      end
      S_WR: begin
        a_ack_d = ~win_b_q;
        b_ack_d = win_b_q;
        state_d = S_END;
      end
      // Address stays on the bus here: the controller decodes it one cycle
      // after the falling edge of port_read.
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock50) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      win_b_q <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 16'd0;
      bit_q   <= 1'b0;
      clk_q   <= 1'b0;
      read_q  <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      rdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      win_b_q <= win_b_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bit_q   <= bit_d;
      clk_q   <= clk_d;
      read_q  <= read_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign rdata     = rdata_q;
  assign port_addr = addr_q;
  assign port_out  = wdata_q;
  assign port_bit  = bit_q;
  assign port_clk  = clk_q;
  assign port_read = read_q;

endmodule

// File: tb/tb_port_bus_arbiter.sv
module tb_port_bus_arbiter;

  logic        clock50;
  logic        reset;
  logic        a_req, b_req;
  logic [15:0] a_addr, b_addr, a_wdata, b_wdata;
  logic        a_we, b_we, a_bit, b_bit;
  logic        a_ack, b_ack;
  logic [15:0] rdata, port_addr, port_out, port_in;
  logic        port_bit, port_clk, port_read;

  port_bus_arbiter #(.READ_WAIT(2)) dut (
    .clock50(clock50), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we), .a_bit(a_bit),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we), .b_bit(b_bit),
    .a_ack(a_ack), .b_ack(b_ack), .rdata(rdata),
    .port_addr(port_addr), .port_out(port_out), .port_bit(port_bit),
    .port_clk(port_clk), .port_read(port_read), .port_in(port_in)
  );

  initial clock50 = 1'b0;
  always #5 clock50 = ~clock50;

  typedef struct packed {
    logic [1:0]  who;   // {a_ack, b_ack}
    logic        rd;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_seen = 0;
  logic prev_ack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock50);
    #1;
  endtask

  // Scoreboard side: every ack pops the oldest expected completion.
  always @(negedge clock50) begin
    exp_t e;
    if (!reset && (a_ack || b_ack)) begin
      ack_seen++;
      chk("ack_one_cycle", {31'd0, prev_ack}, 32'd0);
      if (sb.size() == 0) begin
        chk("ack_unexpected", {30'd0, a_ack, b_ack}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_who", {30'd0, a_ack, b_ack}, {30'd0, e.who});
        if (e.rd) chk("rdata", {16'd0, rdata}, {16'd0, e.data});
      end
    end
    prev_ack = a_ack | b_ack;
  end

  initial begin
    int n;
    reset = 1'b1;
    a_req = 0; b_req = 0; a_we = 0; b_we = 0; a_bit = 0; b_bit = 0;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0; port_in = 16'h0000;
    tick(); tick();
    chk("rst_port_read", {31'd0, port_read}, 0);
    chk("rst_port_clk",  {31'd0, port_clk}, 0);
    chk("rst_acks",      {30'd0, a_ack, b_ack}, 0);
    chk("rst_rdata",     {16'd0, rdata}, 0);
    chk("rst_port_addr", {16'd0, port_addr}, 0);
    reset = 1'b0;
    tick();

    // A read, READ_WAIT=2
    a_req = 1; a_addr = 16'h0060; a_we = 0; a_bit = 1; port_in = 16'h0041;
    sb.push_back('{who: 2'b10, rd: 1'b1, data: 16'h0041});
    tick();
    chk("rd_c1_read", {31'd0, port_read}, 1);
    chk("rd_c1_addr", {16'd0, port_addr}, 16'h0060);
    chk("rd_c1_bit",  {31'd0, port_bit}, 1);
    chk("rd_c1_ack",  {31'd0, a_ack}, 0);
    tick();
    chk("rd_c2_read", {31'd0, port_read}, 1);
    chk("rd_c2_ack",  {31'd0, a_ack}, 0);
    tick();
    chk("rd_end_read", {31'd0, port_read}, 0);
    chk("rd_end_ack",  {31'd0, a_ack}, 1);
    chk("rd_end_data", {16'd0, rdata}, 16'h0041);
    chk("rd_end_addr", {16'd0, port_addr}, 16'h0060);
    a_req = 0;
    port_in = 16'hDEAD;
    tick();
    chk("rd_idle_ack",  {31'd0, a_ack}, 0);
    chk("rd_idle_hold", {16'd0, rdata}, 16'h0041);
    chk("rd_idle_addr", {16'd0, port_addr}, 16'h0060);

    // B write
    b_req = 1; b_addr = 16'h0064; b_wdata = 16'h1234; b_we = 1; b_bit = 0;
    sb.push_back('{who: 2'b01, rd: 1'b0, data: 16'h0000});
    tick();
    chk("wr_clk",   {31'd0, port_clk}, 1);
    chk("wr_out",   {16'd0, port_out}, 16'h1234);
    chk("wr_addr",  {16'd0, port_addr}, 16'h0064);
    chk("wr_read",  {31'd0, port_read}, 0);
    tick();
    chk("wr_clk_drop", {31'd0, port_clk}, 0);
    chk("wr_back",     {31'd0, b_ack}, 1);
    chk("wr_aack",     {31'd0, a_ack}, 0);
    b_req = 0;
    tick();
    chk("wr_idle_back", {31'd0, b_ack}, 0);

    // Simultaneous continuous requests straight after reset
    reset = 1; tick(); reset = 0;
    a_we = 1; b_we = 1; a_wdata = 16'hAAAA; b_wdata = 16'hBBBB;
`ifdef PORT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) sb.push_back('{who: 2'b10, rd: 1'b0, data: 16'h0});
`else
    for (int i = 0; i < 4; i++)
      sb.push_back('{who: (i % 2 == 0) ? 2'b10 : 2'b01, rd: 1'b0, data: 16'h0});
`endif
    a_req = 1; b_req = 1;
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      if (a_ack || b_ack) n++;
    end
    a_req = 0; b_req = 0;
    chk("rr_ack_count", n, 4);
    tick(); tick();
    chk("rr_sb_empty", sb.size(), 0);

    // Reset during the second RD cycle
    a_req = 1; a_we = 0; a_addr = 16'h0070; port_in = 16'h0055;
    tick(); tick(); // now in second RD cycle
    chk("rst_mid_read_hi", {31'd0, port_read}, 1);
    reset = 1; a_req = 0;
    tick();
    chk("rst_mid_read", {31'd0, port_read}, 0);
    chk("rst_mid_acks", {30'd0, a_ack, b_ack}, 0);
    chk("rst_mid_addr", {16'd0, port_addr}, 0);
    chk("rst_mid_rdata", {16'd0, rdata}, 0);
    reset = 0;
    tick(); tick(); tick();
    chk("rst_mid_idle", {29'd0, port_read, port_clk, a_ack}, 0);

    // Protocol violation: req held one IDLE cycle past ack -> exactly one repeat
    n = ack_seen;
    port_in = 16'h0077; a_addr = 16'h0080;
    sb.push_back('{who: 2'b10, rd: 1'b1, data: 16'h0077});
    sb.push_back('{who: 2'b10, rd: 1'b1, data: 16'h0077});
    a_req = 1;
    for (int i = 0; i < 20 && !a_ack; i++) tick();
    chk("pv_first_ack", {31'd0, a_ack}, 1);
    tick(); tick();
    a_req = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("pv_ack_total", ack_seen - n, 2);
    chk("pv_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
